// File: rtl/main_fsm_if.sv
// rtl/main_fsm_if.sv - control bundle between main_fsm and the datapath/condition logic
interface main_fsm_if;
  // Instruction fields and memory handshake seen by the FSM
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;

  // Raw strobes and datapath selects produced by the FSM
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       InstrDone;
  logic       UndefTrap;

  // The FSM side: consumes instruction fields, drives control
  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    output NextPC, RegW, MemW, Branch, ALUOp, InstrDone, UndefTrap
  );

  // The datapath/controller side: supplies fields, consumes control
  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    input  NextPC, RegW, MemW, Branch, ALUOp, InstrDone, UndefTrap
  );
endinterface

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle main control FSM (fetch/decode/execute/writeback); optional MAIN_FSM_UNDEF_TRAP_EN
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECUTER = STATE_W'(6),
    S_EXECUTEI = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
`ifdef MAIN_FSM_UNDEF_TRAP_EN
    S_BRANCH   = STATE_W'(9),
    S_UNDEF    = STATE_W'(10)
`else
    S_BRANCH   = STATE_W'(9)
`endif
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  state_t     r_state;
  state_t     w_next;

  logic       w_irwrite;
  logic       w_adrsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic       w_nextpc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic       w_aluop;
  logic       w_instrdone;
  logic       w_undeftrap;

  // Only I and L are decoded here; the remaining funct bits belong to the ALU decoder
  logic       w_unused_funct;
  assign w_unused_funct = ^bus.Funct[4:1];

  // State register: asynchronous return to FETCH whenever reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode; unlisted selects stay at 0
  always_comb begin
    w_next      = S_FETCH;
    w_irwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_nextpc    = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_branch    = 1'b0;
    w_aluop     = 1'b0;
    w_instrdone = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 computed while the instruction is read from PC
        w_alusrca   = 2'b01;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_irwrite   = bus.MemReady;
        w_nextpc    = bus.MemReady;
        w_next      = bus.MemReady ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Second PC+4 gives the PC+8 value read as R15
        w_alusrca   = 2'b01;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        case (bus.Op)
          OP_DP:   w_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  w_next = S_MEMADR;
          OP_BR:   w_next = S_BRANCH;
`ifdef MAIN_FSM_UNDEF_TRAP_EN
          default: w_next = S_UNDEF;
`else
          default: w_next = S_FETCH;
`endif
        endcase
      end

      S_MEMADR: begin
        // Base register plus extended offset forms the memory address
        w_alusrca = 2'b00;
        w_alusrcb = 2'b01;
        w_next    = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        w_adrsrc    = 1'b1;
        w_resultsrc = 2'b00;
        w_next      = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = 1'b1;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end

      S_MEMWRITE: begin
        // The write strobe is only issued in the cycle memory accepts it
        w_adrsrc    = 1'b1;
        w_resultsrc = 2'b00;
        w_memw      = bus.MemReady;
        w_instrdone = bus.MemReady;
        w_next      = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTER: begin
        w_alusrca = 2'b00;
        w_alusrcb = 2'b00;
        w_aluop   = 1'b1;
        w_next    = S_ALUWB;
      end

      S_EXECUTEI: begin
        w_alusrca = 2'b00;
        w_alusrcb = 2'b01;
        w_aluop   = 1'b1;
        w_next    = S_ALUWB;
      end

      S_ALUWB: begin
        w_resultsrc = 2'b00;
        w_regw      = 1'b1;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end

      S_BRANCH: begin
        // Target = ALUOut (PC+8) + offset, forwarded straight to the PC
        w_alusrca   = 2'b10;
        w_alusrcb   = 2'b01;
        w_resultsrc = 2'b10;
        w_branch    = 1'b1;
        w_instrdone = 1'b1;
        w_next      = S_FETCH;
      end

`ifdef MAIN_FSM_UNDEF_TRAP_EN
      S_UNDEF: begin
        // Parked with all strobes low until reset
        w_next = S_UNDEF;
      end
`endif

      default: begin
        // Stray encodings recover to FETCH with everything low
        w_next = S_FETCH;
      end
    endcase
  end

`ifdef MAIN_FSM_UNDEF_TRAP_EN
  logic r_undef_trap;

  // Sticky trap flag, set on entry to UNDEF and cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_undef_trap <= 1'b0;
    end else if (w_next == S_UNDEF) begin
      r_undef_trap <= 1'b1;
    end
  end

  assign w_undeftrap = r_undef_trap;
`else
  assign w_undeftrap = 1'b0;
`endif

  // All outputs are held low combinationally while reset is asserted
  assign bus.IRWrite   = reset & w_irwrite;
  assign bus.AdrSrc    = reset & w_adrsrc;
  assign bus.ALUSrcA   = reset ? w_alusrca   : 2'b00;
  assign bus.ALUSrcB   = reset ? w_alusrcb   : 2'b00;
  assign bus.ResultSrc = reset ? w_resultsrc : 2'b00;
  assign bus.NextPC    = reset & w_nextpc;
  assign bus.RegW      = reset & w_regw;
  assign bus.MemW      = reset & w_memw;
  assign bus.Branch    = reset & w_branch;
  assign bus.ALUOp     = reset & w_aluop;
  assign bus.InstrDone = reset & w_instrdone;
  assign bus.UndefTrap = reset & w_undeftrap;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - scoreboard bench for main_fsm
module tb_main_fsm;

  logic clk;
  logic reset;

  main_fsm_if bus();

  main_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] sb_q[$];
  int          checks;
  int          errors;
  logic        last_done;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, InstrDone, UndefTrap}
  function automatic logic [14:0] obs();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp, bus.InstrDone, bus.UndefTrap};
  endfunction

  function automatic logic [14:0] mk(input logic irw, input logic adr, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] r, input logic npc,
                                     input logic rw, input logic mw, input logic br,
                                     input logic aop, input logic done, input logic ut);
    return {irw, adr, a, b, r, npc, rw, mw, br, aop, done, ut};
  endfunction

  function automatic logic [14:0] e_fetch(input logic mr);
    return mk(mr, 0, 2'b01, 2'b10, 2'b10, mr, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [14:0] e_decode();
    return mk(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [14:0] e_memadr();
    return mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [14:0] e_memread();
    return mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [14:0] e_memwb();
    return mk(0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [14:0] e_memwrite(input logic mr);
    return mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, mr, 0, 0, mr, 0);
  endfunction
  function automatic logic [14:0] e_exer();
    return mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [14:0] e_exei();
    return mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [14:0] e_aluwb();
    return mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [14:0] e_branch();
    return mk(0, 0, 2'b10, 2'b01, 2'b10, 0, 0, 0, 1, 0, 1, 0);
  endfunction
  function automatic logic [14:0] e_undef();
    return mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Push the expectation, compare against the DUT at the falling edge, then move past the next rising edge
  task automatic cycle(input logic [14:0] exp, input string tag);
    logic [14:0] e;
    logic [14:0] o;
    sb_q.push_back(exp);
    @(negedge clk);
    o = obs();
    e = sb_q.pop_front();
    last_done = o[1];
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    bus.Op    = 2'($urandom);
    bus.Funct = 6'($urandom);
  endtask

  // Runs one instruction from FETCH, checking every cycle and the observed InstrDone latency
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int fw, input int mw, input string tag);
    int n;
    int done_at;
    int lat;
    n = 0;
    done_at = -1;
    for (int i = 0; i < fw; i++) begin
      bus.MemReady = 1'b0; garbage();
      cycle(e_fetch(1'b0), {tag, ":fetch_wait"}); n++;
    end
    bus.MemReady = 1'b1; garbage();
    cycle(e_fetch(1'b1), {tag, ":fetch"}); n++;
    bus.Op = op; bus.Funct = funct; bus.MemReady = 1'($urandom);
    cycle(e_decode(), {tag, ":decode"}); n++;
    case (op)
      2'b00: begin
        garbage();
        cycle(funct[5] ? e_exei() : e_exer(), {tag, ":execute"}); n++;
        garbage();
        cycle(e_aluwb(), {tag, ":aluwb"}); n++;
        if (last_done && done_at < 0) done_at = n;
        lat = 4 + fw;
      end
      2'b01: begin
        bus.Op = op; bus.Funct = funct; bus.MemReady = 1'($urandom);
        cycle(e_memadr(), {tag, ":memadr"}); n++;
        if (funct[0]) begin
          for (int i = 0; i < mw; i++) begin
            bus.MemReady = 1'b0; garbage();
            cycle(e_memread(), {tag, ":memread_wait"}); n++;
          end
          bus.MemReady = 1'b1; garbage();
          cycle(e_memread(), {tag, ":memread"}); n++;
          garbage();
          cycle(e_memwb(), {tag, ":memwb"}); n++;
          if (last_done && done_at < 0) done_at = n;
          lat = 5 + fw + mw;
        end else begin
          for (int i = 0; i < mw; i++) begin
            bus.MemReady = 1'b0; garbage();
            cycle(e_memwrite(1'b0), {tag, ":memwrite_wait"}); n++;
            if (last_done && done_at < 0) done_at = n;
          end
          bus.MemReady = 1'b1; garbage();
          cycle(e_memwrite(1'b1), {tag, ":memwrite"}); n++;
          if (last_done && done_at < 0) done_at = n;
          lat = 4 + fw + mw;
        end
      end
      2'b10: begin
        garbage();
        cycle(e_branch(), {tag, ":branch"}); n++;
        if (last_done && done_at < 0) done_at = n;
        lat = 3 + fw;
      end
      default: begin
`ifdef MAIN_FSM_UNDEF_TRAP_EN
        for (int i = 0; i < 3; i++) begin
          garbage(); bus.MemReady = 1'($urandom);
          cycle(e_undef(), {tag, ":undef"}); n++;
          if (last_done && done_at < 0) done_at = n;
        end
`endif
        lat = -1;
      end
    endcase
    checks++;
    if (done_at != lat) begin
      errors++;
      $display("FAIL %s:latency got %0d expected %0d", tag, done_at, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.MemReady = 1'b1; bus.Op = 2'b00; bus.Funct = 6'b000000;
    for (int i = 0; i < 3; i++) cycle(15'h0, "reset_hold");
    reset = 1'b1;
    run_instr(2'b00, 6'b000000, 0, 0, "reset_first_dp");
  endtask

  task automatic test_dp();
    run_instr(2'b00, 6'b001000, 0, 0, "dp_reg");
    run_instr(2'b00, 6'b100100, 0, 0, "dp_imm");
    run_instr(2'b00, 6'b000010, 2, 0, "dp_fetch_wait");
  endtask

  task automatic test_mem();
    run_instr(2'b01, 6'b011001, 0, 0, "ldr");
    run_instr(2'b01, 6'b011000, 0, 0, "str");
    run_instr(2'b01, 6'b011000, 0, 3, "str_wait");
    run_instr(2'b01, 6'b000001, 1, 2, "ldr_wait");
  endtask

  task automatic test_branch();
    run_instr(2'b10, 6'b101010, 0, 0, "branch");
  endtask

  task automatic test_async_reset();
    logic [14:0] o;
    logic [14:0] e;
    bus.MemReady = 1'b1; garbage();
    cycle(e_fetch(1'b1), "arst:fetch");
    bus.Op = 2'b01; bus.Funct = 6'b000001;
    cycle(e_decode(), "arst:decode");
    cycle(e_memadr(), "arst:memadr");
    bus.MemReady = 1'b0; garbage();
    cycle(e_memread(), "arst:memread");
    #1;
    reset = 1'b0;
    sb_q.push_back(15'h0);
    #1;
    o = obs();
    e = sb_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL arst:immediate got %h expected %h", o, e);
    end
    @(posedge clk); #1;
    bus.MemReady = 1'b1;
    cycle(15'h0, "arst:held");
    reset = 1'b1;
    run_instr(2'b00, 6'b100000, 0, 0, "arst:after_release");
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    for (int k = 0; k < 12; k++) begin
      op = 2'($urandom_range(0, 2));
      run_instr(op, 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "b2b");
    end
  endtask

  task automatic test_undef();
    run_instr(2'b11, 6'b000000, 0, 0, "undef");
`ifdef MAIN_FSM_UNDEF_TRAP_EN
    reset = 1'b0;
    cycle(15'h0, "undef:reset");
    reset = 1'b1;
`endif
    run_instr(2'b10, 6'b000000, 0, 0, "undef:next");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_done = 1'b0;
    reset = 1'b0;
    bus.Op = 2'b00;
    bus.Funct = 6'b000000;
    bus.MemReady = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_dp();
    test_mem();
    test_branch();
    test_async_reset();
    test_back_to_back();
    test_undef();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
